// File: rtl/stack_memory_controller_pkg.sv
// stack_memory_controller_pkg: shared op codes, FSM encoding and memory geometry defaults
package stack_memory_controller_pkg;
  localparam int DEF_DEPTH  = 100;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SP_W   = 7;
  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b001;
  localparam logic [2:0] OP_STORE   = 3'b010;
  localparam logic [2:0] OP_PUSH    = 3'b011;
  localparam logic [2:0] OP_POP     = 3'b100;
  localparam logic [2:0] OP_PEEK    = 3'b101;
  localparam logic [2:0] OP_SPCLR   = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;
endpackage

// File: rtl/stack_memory_controller_sp.sv
// stack_pointer_unit: hardware stack pointer with clear/increment/decrement and full/empty flags
module stack_pointer_unit
  import stack_memory_controller_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SP_W  = DEF_SP_W
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            inc,
  input  logic            dec,
  input  logic            clr,
  output logic [SP_W-1:0] stackPointer,
  output logic            full,
  output logic            empty
);
  // Range is guarded by the controller's accept checks, so no saturation here
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) stackPointer <= '0;
    else if (clr) stackPointer <= '0;
    else if (inc) stackPointer <= stackPointer + 1'b1;
    else if (dec) stackPointer <= stackPointer - 1'b1;
  assign full  = stackPointer == SP_W'(DEPTH);
  assign empty = stackPointer == '0;
endmodule

// File: rtl/stack_memory_controller.sv
// stack_memory_controller: single-request RAM/stack front end with range-checked accesses
module stack_memory_controller
  import stack_memory_controller_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SP_W   = DEF_SP_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        ReqOp,
  input  logic [DATA_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RespValid,
  output logic [DATA_W-1:0] RespData,
  output logic              RespError,
  output logic [SP_W-1:0]   StackPointer,
  output logic              StackEmpty,
  output logic              StackFull,
  output logic [DATA_W-1:0] MemDataIn,
  output logic [DATA_W-1:0] MemAddr,
  output logic              MemWrite,
  output logic              MemUseStk,
  input  logic [DATA_W-1:0] MemDataOut
);
  logic [1:0]        state;
  logic [2:0]        op;
  logic [DATA_W-1:0] addr, data, respData;
  logic              errReg, reqErr, direct, accept, isWrite, isStk, active;
  logic [SP_W-1:0]   stkAddr;
  assign ReqReady = state == ST_IDLE;
  assign accept   = ReqValid && ReqReady;
  assign reqErr   = ((ReqOp == OP_LOAD || ReqOp == OP_STORE) && ReqAddr >= DATA_W'(DEPTH))
                  || (ReqOp == OP_PUSH && StackFull)
                  || ((ReqOp == OP_POP || ReqOp == OP_PEEK) && StackEmpty)
                  || ReqOp == OP_ILLEGAL;
  assign direct   = reqErr || ReqOp == OP_NOP || ReqOp == OP_SPCLR;
  assign isWrite  = op == OP_STORE || op == OP_PUSH;
  assign isStk    = op == OP_PUSH || op == OP_POP || op == OP_PEEK;
  assign active   = state == ST_ACCESS || state == ST_WAIT;
  assign stkAddr  = op == OP_PUSH ? StackPointer : StackPointer - 1'b1;
  // Memory side is decoded from state so an async reset drops MemWrite at once
  assign MemAddr   = !active ? '0 : isStk ? DATA_W'(stkAddr) : addr;
  assign MemUseStk = active && isStk;
  assign MemWrite  = state == ST_ACCESS && isWrite;
  assign MemDataIn = MemWrite ? data : '0;
  assign RespValid = state == ST_RESP;
  assign RespError = RespValid && errReg;
  assign RespData  = RespValid ? respData : '0;
  stack_pointer_unit #(.DEPTH(DEPTH), .SP_W(SP_W)) u_sp (
    .Clock        (Clock),
    .Reset        (Reset),
    .inc          (state == ST_ACCESS && op == OP_PUSH),
    .dec          (state == ST_WAIT && op == OP_POP),
    .clr          (accept && ReqOp == OP_SPCLR),
    .stackPointer (StackPointer),
    .full         (StackFull),
    .empty        (StackEmpty)
  );
  // Request FSM: latch and check at accept, access memory, wait for registered read, respond
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state    <= ST_IDLE;
      op       <= OP_NOP;
      addr     <= '0;
      data     <= '0;
      errReg   <= 1'b0;
      respData <= '0;
    end else begin
      case (state)
        ST_IDLE: if (ReqValid) begin
          op       <= ReqOp;
          addr     <= ReqAddr;
          data     <= ReqData;
          errReg   <= reqErr;
          respData <= '0;
          state    <= direct ? ST_RESP : ST_ACCESS;
        end
        ST_ACCESS: state <= isWrite ? ST_RESP : ST_WAIT;
        ST_WAIT: begin
          respData <= MemDataOut;
          state    <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_stack_memory_controller.sv
// tb_stack_memory_controller: directed scoreboard bench with a behavioural RAM/stack memory
module tb_stack_memory_controller;
  import stack_memory_controller_pkg::*;
  logic        Clock = 0, Reset = 0, ReqValid = 0;
  logic        ReqReady, RespValid, RespError, StackEmpty, StackFull, MemWrite, MemUseStk;
  logic [2:0]  ReqOp = 0;
  logic [31:0] ReqAddr = 0, ReqData = 0, RespData, MemDataIn, MemAddr, MemDataOut = 0;
  logic [6:0]  StackPointer;
  typedef struct { logic [31:0] data; logic err; int lat; int acc; int sp; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, hs = 0, nIssued = 0, wrCnt = 0, wrMark;
  logic [31:0] ram [DEF_DEPTH];
  logic [31:0] stk [DEF_DEPTH];

  stack_memory_controller dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .RespValid(RespValid), .RespData(RespData),
    .RespError(RespError), .StackPointer(StackPointer), .StackEmpty(StackEmpty),
    .StackFull(StackFull), .MemDataIn(MemDataIn), .MemAddr(MemAddr), .MemWrite(MemWrite),
    .MemUseStk(MemUseStk), .MemDataOut(MemDataOut)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (Reset && ReqValid && ReqReady) hs <= hs + 1;
    if (MemWrite) wrCnt <= wrCnt + 1;
  end

  always @(posedge Clock) begin
    if (MemWrite && MemAddr < DEF_DEPTH) begin
      if (MemUseStk) stk[MemAddr[6:0]] <= MemDataIn;
      else ram[MemAddr[6:0]] <= MemDataIn;
    end
    MemDataOut <= MemAddr < DEF_DEPTH ? (MemUseStk ? stk[MemAddr[6:0]] : ram[MemAddr[6:0]]) : 32'h0;
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] d, logic [31:0] ed,
                       logic ee, int lat, int sp, bit hold);
    int n = 0;
    exp_t e;
    @(negedge Clock);
    ReqValid = 1; ReqOp = op; ReqAddr = a; ReqData = d;
    while (!ReqReady && n < 20) begin @(negedge Clock); n++; end
    if (!ReqReady) begin
      chk("accept_timeout", 0, 1);
      ReqValid = 0;
      return;
    end
    @(posedge Clock);
    e.data = ed; e.err = ee; e.lat = lat; e.acc = cyc; e.sp = sp;
    q.push_back(e);
    nIssued++;
    if (!hold) begin @(negedge Clock); ReqValid = 0; end
  endtask

  always @(negedge Clock) begin : monitor
    exp_t e;
    if (Reset && RespValid) begin
      if (q.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        e = q.pop_front();
        chk("resp_data", RespData, e.data);
        chk("resp_error", RespError, e.err);
        chk("latency", cyc - e.acc, e.lat);
        chk("sp", StackPointer, e.sp);
        chk("empty", StackEmpty, e.sp == 0);
        chk("full", StackFull, e.sp == DEF_DEPTH);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge Clock);
    Reset = 1;
    @(negedge Clock);
    chk("reset_ready", ReqReady, 1);
    chk("reset_respvalid", RespValid, 0);
    chk("reset_sp", StackPointer, 0);
    // reset in the middle of a PUSH access
    ReqValid = 1; ReqOp = OP_PUSH; ReqData = 32'h99;
    @(posedge Clock);
    nIssued++;
    #1 chk("t1_memwrite_access", MemWrite, 1);
    Reset = 0; ReqValid = 0;
    #1 chk("t1_memwrite_reset", MemWrite, 0);
    chk("t1_usestk_reset", MemUseStk, 0);
    @(negedge Clock); Reset = 1;
    repeat (3) @(negedge Clock);
    chk("t1_sp", StackPointer, 0);
    chk("t1_empty", StackEmpty, 1);
    // RAM store then load
    issue(OP_STORE, 5, 32'hDEADBEEF, 0, 0, 2, 0, 0);
    issue(OP_LOAD, 5, 0, 32'hDEADBEEF, 0, 3, 0, 0);
    issue(OP_NOP, 0, 0, 0, 0, 1, 0, 0);
    // stack sequence
    issue(OP_PUSH, 0, 32'h11, 0, 0, 2, 1, 0);
    issue(OP_PUSH, 0, 32'h22, 0, 0, 2, 2, 0);
    issue(OP_PEEK, 0, 0, 32'h22, 0, 3, 2, 0);
    issue(OP_POP, 0, 0, 32'h22, 0, 3, 1, 0);
    issue(OP_POP, 0, 0, 32'h11, 0, 3, 0, 0);
    // rejected requests never write memory
    repeat (3) @(negedge Clock);
    wrMark = wrCnt;
    issue(OP_POP, 0, 0, 0, 1, 1, 0, 0);
    issue(OP_LOAD, 100, 0, 0, 1, 1, 0, 0);
    issue(OP_STORE, 32'hFFFFFFFF, 32'h5A5A, 0, 1, 1, 0, 0);
    issue(OP_ILLEGAL, 0, 0, 0, 1, 1, 0, 0);
    repeat (3) @(negedge Clock);
    chk("err_no_memwrite", wrCnt, wrMark);
    // fill the stack, overflow, then clear
    for (int i = 0; i < DEF_DEPTH; i++) issue(OP_PUSH, 0, i, 0, 0, 2, i + 1, 0);
    repeat (3) @(negedge Clock);
    wrMark = wrCnt;
    issue(OP_PUSH, 0, 32'hAA, 0, 1, 1, DEF_DEPTH, 0);
    repeat (3) @(negedge Clock);
    chk("overflow_no_memwrite", wrCnt, wrMark);
    issue(OP_PEEK, 0, 0, DEF_DEPTH - 1, 0, 3, DEF_DEPTH, 0);
    issue(OP_SPCLR, 0, 0, 0, 0, 1, 0, 0);
    // request held valid across a load
    issue(OP_LOAD, 5, 0, 32'hDEADBEEF, 0, 3, 0, 1);
    repeat (3) begin @(negedge Clock); chk("t6_ready_low", ReqReady, 0); end
    issue(OP_LOAD, 5, 0, 32'hDEADBEEF, 0, 3, 0, 0);
    n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge Clock); n++; end
    chk("drain", q.size(), 0);
    repeat (3) @(negedge Clock);
    chk("handshakes", hs, nIssued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_memory_controller.md
Name: stack_memory_controller

Overview:
Sits directly upstream of the data RAM/stack memory and is the only block that drives its DataIn/Addr/WriteMem/useStk inputs and consumes its DataOut. Accepts one request at a time from the core (LOAD/STORE to RAM, PUSH/POP/PEEK on the stack) and owns the hardware stack pointer. Checks every access against depth limits, so the memory never sees an out-of-range address or an overflowing push.

Parameters:
DEPTH, 100, words in each of RAM and stack; must match the memory array depth
DATA_W, 32, data and address width
SP_W, 7, stack pointer width, equal to ceil(log2(DEPTH+1))

Ports:
Clock  in  1  single system clock; the memory's Clock and ClockAuto are both tied to this net
Reset  in  1  asynchronous, active-low reset
ReqValid  in  1  request present
ReqReady  out  1  controller can accept; handshake on ReqValid && ReqReady at rising Clock
ReqOp  in  3  000 NOP, 001 LOAD, 010 STORE, 011 PUSH, 100 POP, 101 PEEK, 110 SPCLR, 111 illegal
ReqAddr  in  DATA_W  RAM word address for LOAD/STORE; ignored otherwise
ReqData  in  DATA_W  write data for STORE/PUSH
RespValid  out  1  one-cycle completion pulse
RespData  out  DATA_W  read data for LOAD/POP/PEEK; 0 otherwise
RespError  out  1  qualifies RespValid; the request was rejected
StackPointer  out  SP_W  next free stack slot
StackEmpty  out  1  StackPointer == 0
StackFull  out  1  StackPointer == DEPTH
MemDataIn  out  DATA_W  to memory DataIn
MemAddr  out  DATA_W  to memory Addr
MemWrite  out  1  to memory WriteMem
MemUseStk  out  1  to memory useStk
MemDataOut  in  DATA_W  from memory DataOut; registered, valid one edge after MemAddr/MemUseStk are stable

Behaviour:
- Reset asserted (async): state IDLE, SP=0, ReqReady=1, RespValid=0, RespError=0, RespData=0, MemWrite=0, MemUseStk=0, MemAddr=0, MemDataIn=0. Takes effect mid-operation without completing the access and without a response.
- FSM: IDLE, ACCESS, WAIT, RESP. ReqReady=1 only in IDLE.
- Accept in IDLE: latch the op, address and data.
  - Error check at accept:
    - LOAD/STORE with ReqAddr >= DEPTH
    - PUSH when StackFull
    - POP/PEEK when StackEmpty
    - op 111
  - Error -> RESP directly, with RespError=1, RespData=0, no memory write, SP unchanged.
  - NOP and SPCLR -> RESP directly. SPCLR sets SP=0 on the accept edge.
- ACCESS: drive MemAddr/MemUseStk.
  - STORE: MemAddr=addr, MemUseStk=0, MemWrite=1, MemDataIn=data.
  - PUSH: MemAddr=SP, MemUseStk=1, MemWrite=1, MemDataIn=data. SP increments at end of ACCESS.
  - LOAD: MemAddr=addr, MemUseStk=0, MemWrite=0.
  - POP/PEEK: MemAddr=SP-1, MemUseStk=1, MemWrite=0.
  - Next state: writes -> RESP; reads -> WAIT.
- WAIT: MemAddr/MemUseStk held, MemWrite=0. The memory registers its read at the WAIT entry edge. RespData captures MemDataOut at the end of WAIT. POP decrements SP at the end of WAIT.
- RESP: RespValid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- MemWrite is high only in ACCESS for STORE/PUSH. It is 0 in every other state.
- Latency from the accept edge to the RespValid cycle: 1 cycle for error/NOP/SPCLR, 2 for STORE/PUSH, 3 for LOAD/POP/PEEK. Throughput is one request per latency+1 cycles.
- SP never wraps; the range 0..DEPTH is guaranteed by the checks. ReqValid with ReqReady=0 is ignored, and the requester holds the request.
- StackEmpty/StackFull are combinational from the SP register.

Decomposition:
- Shared package holds:
  - op-code constants (OP_NOP..OP_ILLEGAL)
  - FSM state encoding
  - the DEPTH/DATA_W defaults, shared with the memory instance
- One natural sub-module: stack_pointer_unit, which holds the SP register, increment/decrement/clear and the Full/Empty flags.
- The FSM and memory-side muxing stay in the top.

Test Plan:
1. Reset low mid-PUSH (in ACCESS) -> MemWrite=0 immediately. After release: SP=0, StackEmpty=1, no RespValid.
2. STORE addr 5 data 0xDEADBEEF, then LOAD addr 5:
   - STORE: RespValid 2 cycles after accept, RespError=0.
   - LOAD: RespData=0xDEADBEEF 3 cycles after accept.
3. PUSH 0x11, PUSH 0x22, PEEK, POP, POP:
   - Responses 0x22, 0x22, 0x11.
   - SP sequence 1, 2, 2, 1, 0.
   - Final StackEmpty=1.
4. POP on empty stack -> RespValid+RespError 1 cycle after accept, RespData=0, SP stays 0, no MemWrite. 100 PUSHes then a 101st -> StackFull=1, 101st RespError=1, SP stays 100.
5. LOAD addr 100 and STORE addr 0xFFFFFFFF -> both RespError=1, MemWrite never asserted. Op 111 -> RespError=1.
6. ReqValid held high across a 3-cycle LOAD -> exactly one acceptance per IDLE cycle, no duplicate request, ReqReady low in ACCESS/WAIT/RESP.
